// File: rtl/jtag_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module  : jtag_cmd_sched
// Brief   : Two-requester JTAG master with round-robin/lockable arbitration,
//           divided TCK generation, bit sequencing and TDO capture.
// Rev     : 1.0
// ============================================================================
module jtag_cmd_sched #(
    parameter int TCK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [9:0]  req_len,
    input  logic [63:0] req_data,
    input  logic [1:0]  req_lock,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        owner,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);

    localparam logic [1:0] C_IDLE       = 2'd0;
    localparam logic [1:0] C_LO         = 2'd1;
    localparam logic [1:0] C_HI         = 2'd2;
    localparam logic [1:0] C_RESP       = 2'd3;
    localparam logic [1:0] C_CMD_RESET  = 2'd0;
    localparam logic [1:0] C_CMD_TMS    = 2'd1;
    localparam logic [1:0] C_CMD_SCAN   = 2'd2;
    localparam logic [1:0] C_CMD_FLIP   = 2'd3;
    localparam logic [7:0] C_DIV_LAST   = 8'(TCK_DIV - 1);
    localparam logic [4:0] C_RESET_LAST = 5'd5;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [1:0]  r_cmd;
    logic [31:0] r_data;
    logic [4:0]  r_last_bit;
    logic [4:0]  r_bit;
    logic [7:0]  r_div;
    logic [31:0] r_cap;
    logic        r_owner;
    logic        r_prev_gnt;
    logic        r_lock;
    logic        r_busy;
    logic        r_tck;
    logic        r_tms;
    logic        r_tdi;

    logic        w_gnt_vld;
    logic        w_gnt_idx;
    logic        w_div_tc;
    logic        w_bit_last;
    logic [1:0]  w_cmd_in;
    logic [4:0]  w_len_in;
    logic [31:0] w_data_in;
    logic [4:0]  w_last_in;
    logic [1:0]  w_drv_first;
    logic [1:0]  w_drv_next;

    // Returns {tms, tdi} for bit k of a command.
    function automatic logic [1:0] f_drive(input logic [1:0]  cmd,
                                           input logic [31:0] data,
                                           input logic [4:0]  k,
                                           input logic [4:0]  last);
        logic [1:0] v;
        case (cmd)
            C_CMD_RESET: v = {(k != C_RESET_LAST), 1'b0};
            C_CMD_TMS:   v = {data[k], 1'b0};
            C_CMD_SCAN:  v = {1'b0, data[k]};
            default:     v = {(k == last), data[k]};
        endcase
        return v;
    endfunction

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = 1'b0;
        if (r_state == C_IDLE) begin
            if (r_lock) begin
                w_gnt_vld = req_valid[r_owner];
                w_gnt_idx = r_owner;
            end else if (&req_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = ~r_prev_gnt;
            end else if (|req_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = req_valid[1];
            end
        end
    end

    assign w_cmd_in    = w_gnt_idx ? req_cmd[3:2]    : req_cmd[1:0];
    assign w_len_in    = w_gnt_idx ? req_len[9:5]    : req_len[4:0];
    assign w_data_in   = w_gnt_idx ? req_data[63:32] : req_data[31:0];
    assign w_last_in   = (w_cmd_in == C_CMD_RESET) ? C_RESET_LAST : w_len_in;
    assign w_drv_first = f_drive(w_cmd_in, w_data_in, 5'd0, w_last_in);
    assign w_drv_next  = f_drive(r_cmd, r_data, r_bit + 5'd1, r_last_bit);
    assign w_div_tc    = (r_div == C_DIV_LAST);
    assign w_bit_last  = (r_bit == r_last_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE: if (w_gnt_vld) w_state_nxt = C_LO;
            C_LO:   if (w_div_tc) w_state_nxt = C_HI;
            C_HI:   if (w_div_tc) w_state_nxt = w_bit_last ? C_RESP : C_LO;
            C_RESP: if (rsp_ready[r_owner]) w_state_nxt = C_IDLE;
            default: w_state_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd      <= C_CMD_RESET;
            r_data     <= 32'd0;
            r_last_bit <= 5'd0;
            r_bit      <= 5'd0;
            r_div      <= 8'd0;
            r_cap      <= 32'd0;
            r_owner    <= 1'b0;
            r_prev_gnt <= 1'b1;
            r_lock     <= 1'b0;
            r_busy     <= 1'b0;
            r_tck      <= 1'b0;
            r_tms      <= 1'b0;
            r_tdi      <= 1'b0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (r_lock && !req_lock[r_owner]) begin
                        r_lock <= 1'b0;
                    end
                    if (w_gnt_vld) begin
                        r_owner    <= w_gnt_idx;
                        r_prev_gnt <= w_gnt_idx;
                        r_busy     <= 1'b1;
                        r_cmd      <= w_cmd_in;
                        r_data     <= w_data_in;
                        r_last_bit <= w_last_in;
                        r_bit      <= 5'd0;
                        r_div      <= 8'd0;
                        r_cap      <= 32'd0;
                        r_tms      <= w_drv_first[1];
                        r_tdi      <= w_drv_first[0];
                    end
                end
                C_LO: begin
                    if (w_div_tc) begin
                        r_div        <= 8'd0;
                        r_tck        <= 1'b1;
                        r_cap[r_bit] <= tdo;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                C_HI: begin
                    if (w_div_tc) begin
                        r_div <= 8'd0;
                        r_tck <= 1'b0;
                        if (w_bit_last) begin
                            r_tms <= 1'b0;
                            r_tdi <= 1'b0;
                        end else begin
                            r_bit <= r_bit + 5'd1;
                            r_tms <= w_drv_next[1];
                            r_tdi <= w_drv_next[0];
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                default: begin
                    if (rsp_ready[r_owner]) begin
                        r_lock <= req_lock[r_owner];
                        r_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        rsp_data  = 32'd0;
        if (w_gnt_vld) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
        if (r_state == C_RESP) begin
            rsp_valid[r_owner] = 1'b1;
            if (r_cmd == C_CMD_SCAN || r_cmd == C_CMD_FLIP) begin
                rsp_data = r_cap;
            end
        end
    end

    assign busy  = r_busy;
    assign owner = r_owner;
    assign tck   = r_tck;
    assign tms   = r_tms;
    assign tdi   = r_tdi;

endmodule
`default_nettype wire

// File: tb/tb_jtag_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_jtag_cmd_sched
// Brief   : Directed + randomized bench for jtag_cmd_sched with a transaction
//           level arbitration/JTAG model and a one-TCK loopback target.
// Rev     : 1.0
// ============================================================================
module tb_jtag_cmd_sched;

    localparam int         DIV    = 2;
    localparam logic [1:0] RST_C  = 2'd0;
    localparam logic [1:0] TMS_C  = 2'd1;
    localparam logic [1:0] SCAN_C = 2'd2;
    localparam logic [1:0] FLIP_C = 2'd3;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_lock  = 2'b00;
    logic [1:0]  rsp_ready = 2'b00;
    logic [3:0]  req_cmd   = 4'd0;
    logic [9:0]  req_len   = 10'd0;
    logic [63:0] req_data  = 64'd0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        busy, owner, tck, tms, tdi, tdo;

    jtag_cmd_sched #(.TCK_DIV(DIV)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_len   (req_len),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .owner     (owner),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    always #5 clk = ~clk;

    // Target: TDO returns TDI delayed by one TCK.
    logic r_tgt;
    always @(posedge tck or negedge rst_n) begin
        if (!rst_n) r_tgt <= 1'b0;
        else        r_tgt <= tdi;
    end
    assign tdo = r_tgt;

    int          mon_n   = 0;
    logic [31:0] mon_tms = 32'd0;
    logic [31:0] mon_tdi = 32'd0;
    always @(posedge tck) begin
        mon_tms <= {tms, mon_tms[31:1]};
        mon_tdi <= {tdi, mon_tdi[31:1]};
        mon_n   <= mon_n + 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    endtask

    // Reference model state
    logic        m_lock;
    int          m_last;
    int          m_owner;
    logic        m_prev;
    logic        p_valid [2];
    logic [1:0]  p_cmd   [2];
    logic [4:0]  p_len   [2];
    logic [31:0] p_data  [2];
    logic        p_lock  [2];

    task automatic model_reset();
        m_lock  = 1'b0;
        m_last  = 1;
        m_owner = 0;
        m_prev  = 1'b0;
        for (int i = 0; i < 2; i++) p_valid[i] = 1'b0;
    endtask

    task automatic set_cmd(input int i, input logic [1:0] c, input logic [4:0] l,
                           input logic [31:0] d, input logic lk);
        p_valid[i] = 1'b1;
        p_cmd[i]   = c;
        p_len[i]   = l;
        p_data[i]  = d;
        p_lock[i]  = lk;
    endtask

    task automatic rand_cmd(input int i, input logic lk);
        set_cmd(i, 2'($urandom), 5'($urandom), $urandom, lk);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 2; i++) begin
            req_valid[i]         = p_valid[i];
            req_cmd[2*i +: 2]    = p_valid[i] ? p_cmd[i]  : 2'($urandom);
            req_len[5*i +: 5]    = p_valid[i] ? p_len[i]  : 5'($urandom);
            req_data[32*i +: 32] = p_valid[i] ? p_data[i] : $urandom;
            req_lock[i]          = p_valid[i] & p_lock[i];
        end
    endtask

    task automatic wait_grant(output bit ok);
        int n = 0;
        #1;
        while (req_ready == 2'b00 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (req_ready != 2'b00);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_jtag"}, 64'({tck, tms, tdi}), 64'd0);
        chk({tag, "_ctl"},  64'({req_ready, rsp_valid, busy, owner}), 64'd0);
        chk({tag, "_data"}, 64'(rsp_data), 64'd0);
    endtask

    task automatic do_round(output int win);
        int          n, nb, c0, base;
        bit          ok;
        logic [1:0]  cmd;
        logic [31:0] data, mask, e_tms, e_tdi, e_cap;
        logic        lk;
        if (m_lock && p_valid[m_owner])    win = m_owner;
        else if (p_valid[0] && p_valid[1]) win = 1 - m_last;
        else                               win = p_valid[1] ? 1 : 0;
        cmd  = p_cmd[win];
        data = p_data[win];
        lk   = p_lock[win];
        nb   = (cmd == RST_C) ? 6 : int'(p_len[win]) + 1;
        mask = (nb == 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
        e_tms = 32'd0;
        e_tdi = 32'd0;
        e_cap = 32'd0;
        case (cmd)
            RST_C:   e_tms = 32'h0000_001F;
            TMS_C:   e_tms = data & mask;
            SCAN_C:  e_tdi = data & mask;
            default: begin
                e_tdi = data & mask;
                e_tms = 32'd1 << (nb - 1);
            end
        endcase
        if (cmd == SCAN_C || cmd == FLIP_C) e_cap = ((data << 1) | {31'd0, m_prev}) & mask;

        drive_inputs();
        wait_grant(ok);
        chk("grant", 64'(req_ready), 64'(2'b01 << win));
        if (!ok) finish_run();
        c0   = cyc;
        base = mon_n;
        @(negedge clk);
        chk("owner", 64'(owner), 64'(win));
        chk("busy_on", 64'(busy), 64'd1);
        p_valid[win] = 1'b0;
        drive_inputs();
        req_lock[win] = lk;

        n = 0;
        while (rsp_valid == 2'b00 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("duration", 64'(cyc - c0), 64'(nb * 2 * DIV + 1));
        if (rsp_valid == 2'b00) finish_run();
        chk("rsp_valid", 64'(rsp_valid), 64'(2'b01 << win));
        chk("rsp_data", 64'(rsp_data), 64'(e_cap));
        chk("tck_pulses", 64'(mon_n - base), 64'(nb));
        chk("tms_bits", 64'(mon_tms >> (32 - nb)), 64'(e_tms));
        chk("tdi_bits", 64'(mon_tdi >> (32 - nb)), 64'(e_tdi));
        chk("jtag_idle", 64'({tck, tms, tdi}), 64'd0);
        chk("ready_busy", 64'(req_ready), 64'd0);

        rsp_ready[1 - win] = 1'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        chk("rsp_hold", 64'({rsp_valid, rsp_data}), 64'({2'b01 << win, e_cap}));
        rsp_ready[win] = 1'b1;
        @(negedge clk);
        chk("rsp_done", 64'({busy, rsp_valid}), 64'd0);
        rsp_ready = 2'b00;

        m_lock  = lk;
        m_last  = win;
        m_owner = win;
        m_prev  = (cmd == SCAN_C || cmd == FLIP_C) ? data[nb - 1] : 1'b0;
    endtask

    task automatic abort_test();
        bit          ok;
        int          n, base;
        logic [31:0] d;
        d = $urandom;
        set_cmd(0, SCAN_C, 5'd15, d, 1'b0);
        drive_inputs();
        wait_grant(ok);
        chk("abort_grant", 64'(req_ready), 64'd1);
        if (!ok) finish_run();
        base = mon_n;
        @(negedge clk);
        p_valid[0] = 1'b0;
        drive_inputs();
        n = 0;
        while (mon_n - base < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (DIV + 1) @(negedge clk);
        chk("abort_bit3", 64'({tck, tms, tdi}), 64'({2'b00, d[3]}));
        #2 rst_n = 1'b0;
        #1 chk_reset("async_rst");
        repeat (3) @(negedge clk);
        chk("abort_no_rsp", 64'({busy, rsp_valid}), 64'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        finish_run();
    end

    initial begin
        int w;
        model_reset();
        drive_inputs();
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;
        @(negedge clk);

        set_cmd(0, RST_C, 5'd3, 32'hFFFF_FFFF, 1'b0);
        do_round(w);
        set_cmd(0, SCAN_C, 5'd7, 32'h0000_00A5, 1'b0);
        do_round(w);
        set_cmd(0, FLIP_C, 5'd31, 32'hDEAD_BEEF, 1'b0);
        do_round(w);

        abort_test();

        for (int i = 0; i < 4; i++) begin
            if (!p_valid[0]) rand_cmd(0, 1'b0);
            if (!p_valid[1]) rand_cmd(1, 1'b0);
            do_round(w);
            chk("alt_order", 64'(w), 64'(i % 2));
        end

        set_cmd(1, SCAN_C, 5'($urandom), $urandom, 1'b1);
        do_round(w);
        chk("lock_seq0", 64'(w), 64'd0);
        rand_cmd(0, 1'b0);
        do_round(w);
        chk("lock_seq1", 64'(w), 64'd1);
        set_cmd(1, TMS_C, 5'($urandom), $urandom, 1'b0);
        do_round(w);
        chk("lock_seq2", 64'(w), 64'd1);
        do_round(w);
        chk("lock_seq3", 64'(w), 64'd0);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 2; i++) begin
                if (p_valid[i] && $urandom_range(0, 5) == 0)
                    p_valid[i] = 1'b0;
                else if (!p_valid[i] && $urandom_range(0, 2) != 0)
                    rand_cmd(i, 1'($urandom_range(0, 3) == 0));
            end
            if (!p_valid[0] && !p_valid[1]) rand_cmd(int'($urandom_range(0, 1)), 1'b0);
            do_round(w);
        end

        finish_run();
    end

endmodule
`default_nettype wire
